// File: rtl/position_rate_estimator_if.sv
// AXI-Stream beat bundle (valid/ready/data) shared by the position input and delta output.
`timescale 1ns/1ps
interface position_rate_estimator_if #(
  parameter int W = 32
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/position_rate_estimator.sv
// Windowed displacement of a position stream: delta valid 1 clk after the closing beat.
// Input never stalls; a result arriving while the one-entry output register is blocked is dropped and counted.
`timescale 1ns/1ps
module position_rate_estimator #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int LOG_MAX_WINDOW   = 20
) (
  input  logic                             SYS_aclk,
  input  logic                             SYS_reset,
  input  logic                             FC_enable,
  input  logic [4:0]                       FC_log_window,
  position_rate_estimator_if.slave         s_axis,
  position_rate_estimator_if.master        m_axis,
  output logic [15:0]                      STAT_overrun_count
);
  localparam int W  = AXIS_TDATA_WIDTH;
  localparam int CW = (LOG_MAX_WINDOW > 0) ? LOG_MAX_WINDOW : 1;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ref_q, ref_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    win_q, win_d;
  logic          tvalid_q, tvalid_d;
  logic [W-1:0]  tdata_q, tdata_d;
  logic [15:0]   ovr_q, ovr_d;

  logic [4:0]    log_clamped;
  logic [CW:0]   win_span;
  logic [CW-1:0] last_cnt;
  logic [W-1:0]  delta;
  logic          beat;
  logic          result;

  assign s_axis.tready = 1'b1;
  assign beat          = s_axis.tvalid;
  assign log_clamped   = (FC_log_window > 5'(LOG_MAX_WINDOW)) ? 5'(LOG_MAX_WINDOW) : FC_log_window;
  assign win_span      = ((CW+1)'(1) << win_q) - (CW+1)'(1);
  assign last_cnt      = win_span[CW-1:0];
  // Modulo subtraction keeps deltas correct across position wrap-around.
  assign delta         = s_axis.tdata - ref_q;

  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    result  = 1'b0;
    if (!FC_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: begin
          if (beat) begin
            ref_d   = s_axis.tdata;
            cnt_d   = '0;
            win_d   = log_clamped;
            state_d = RUN;
          end
        end
        RUN: begin
          if (beat) begin
            if (cnt_q == last_cnt) begin
              result = 1'b1;
              ref_d  = s_axis.tdata;
              cnt_d  = '0;
              win_d  = log_clamped;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // The holding register can take a new result when empty or draining this cycle.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    ovr_d    = ovr_q;
    if (result) begin
      if (!tvalid_q || m_axis.tready) begin
        tvalid_d = 1'b1;
        tdata_d  = delta;
      end else if (ovr_q != 16'hFFFF) begin
        ovr_d = ovr_q + 16'd1;
      end
    end else if (tvalid_q && m_axis.tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge SYS_aclk) begin
    if (SYS_reset) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      cnt_q    <= '0;
      win_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis.tvalid      = tvalid_q;
  assign m_axis.tdata       = tdata_q;
  assign STAT_overrun_count = ovr_q;
endmodule
